// File: rtl/stride_prefetcher_pkg.sv
// Shared definitions for the stride prefetcher.
//   - Address/block geometry constants and default sizing parameters.
//   - FSM state encoding (IDLE / UPDATE / ISSUE).
//   - Stream-table entry layout (valid, tag, last block, stride, confidence).
package stride_prefetcher_pkg;

    localparam int ADDR_W      = 32;                   // byte address width
    localparam int BLOCK_OFF   = 4;                    // log2 block size in bytes
    localparam int REGION_BITS = 12;                   // log2 bytes per tracked region
    localparam int STRIDE_W    = 8;                    // signed stride width in blocks
    localparam int BLK_W       = ADDR_W - BLOCK_OFF;   // block number width
    localparam int TAG_W       = ADDR_W - REGION_BITS; // stream tag width

    localparam logic [1:0] CONF_MAX = 2'd3;

    // Default sizing for the parametrised top level.
    localparam int DEF_ENTRIES     = 4;
    localparam int DEF_CONF_THRESH = 2;
    localparam int DEF_DEGREE      = 2;
    localparam int DEF_PF_BUF      = 8;
    localparam int DEF_CNT_W       = 20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_ISSUE  = 2'd2
    } state_t;

    typedef struct packed {
        logic                       valid;
        logic [TAG_W-1:0]           tag;
        logic [BLK_W-1:0]           last;
        logic signed [STRIDE_W-1:0] stride;
        logic [1:0]                 conf;
    } stream_entry_t;

endpackage

// File: rtl/stride_prefetcher_if.sv
// Bus between the L1 side and the stride prefetcher.
//   miss_valid/miss_addr     : L1 miss pulse and byte address
//   lookup_valid/lookup_addr : L1 lookup probing the issued-block buffer
//   prefetch_hit             : registered lookup result (one cycle later)
//   pf_valid/pf_addr/pf_ready: prefetch request handshake. A beat transfers on
//                              a rising edge where pf_valid && pf_ready; while
//                              pf_valid is high and pf_ready low, pf_addr is
//                              held stable.
//   busy                     : prefetcher FSM not idle
//   issued_count/useful_count: saturating statistics
// slave = prefetcher side, master = L1/driver side.
interface stride_prefetcher_if #(
    parameter int CNT_W = stride_prefetcher_pkg::DEF_CNT_W
);
    import stride_prefetcher_pkg::*;

    logic              miss_valid;
    logic [ADDR_W-1:0] miss_addr;
    logic              lookup_valid;
    logic [ADDR_W-1:0] lookup_addr;
    logic              prefetch_hit;
    logic              pf_valid;
    logic [ADDR_W-1:0] pf_addr;
    logic              pf_ready;
    logic              busy;
    logic [CNT_W-1:0]  issued_count;
    logic [CNT_W-1:0]  useful_count;

    modport slave (
        input  miss_valid, miss_addr, lookup_valid, lookup_addr, pf_ready,
        output prefetch_hit, pf_valid, pf_addr, busy, issued_count, useful_count
    );

    modport master (
        output miss_valid, miss_addr, lookup_valid, lookup_addr, pf_ready,
        input  prefetch_hit, pf_valid, pf_addr, busy, issued_count, useful_count
    );

endinterface

// File: rtl/stride_prefetcher_pf_issue_buffer.sv
// Issued-block buffer: a PF_BUF-entry CAM written in FIFO order (oldest slot
// overwritten) with each accepted prefetch block. A lookup compares against
// the contents before any write of the same cycle, invalidates matching
// entries and registers the hit flag for the following cycle.
//   i_clk, i_reset     : clock, async active-low reset
//   i_wr_en, i_wr_blk  : write an issued block number
//   i_lookup_valid/blk : lookup probe (block number)
//   o_match            : combinational match this cycle (for statistics)
//   o_hit              : registered match, valid the cycle after the lookup
module stride_prefetcher_pf_issue_buffer #(
    parameter int PF_BUF = 8,
    parameter int BLK_W  = 28
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wr_en,
    input  logic [BLK_W-1:0] i_wr_blk,
    input  logic             i_lookup_valid,
    input  logic [BLK_W-1:0] i_lookup_blk,
    output logic             o_match,
    output logic             o_hit
);
    localparam int PTR_W = (PF_BUF > 1) ? $clog2(PF_BUF) : 1;

    logic [PF_BUF-1:0] r_valid;
    logic [BLK_W-1:0]  r_blk [PF_BUF];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic              r_hit;
    logic [PF_BUF-1:0] w_match_vec;
    logic [PF_BUF-1:0] w_wr_mask;

    // The same block can be issued twice by overlapping triggers; every copy
    // is dropped on a hit so a block counts as useful only once.
    always_comb begin
        w_match_vec = '0;
        for (int i = 0; i < PF_BUF; i++) begin
            w_match_vec[i] = i_lookup_valid && r_valid[i] && (r_blk[i] == i_lookup_blk);
        end
    end

    assign o_match   = |w_match_vec;
    assign w_wr_mask = i_wr_en ? (PF_BUF'(1) << r_wr_ptr) : '0;
    assign o_hit     = r_hit;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_hit    <= 1'b0;
        end else begin
            r_hit <= o_match;
            // A write into a slot being invalidated keeps the new block valid.
            r_valid <= (r_valid & ~w_match_vec) | w_wr_mask;
            if (i_wr_en) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(PF_BUF - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
        end
    end

    // Block storage needs no reset; the valid bits qualify it.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_blk[r_wr_ptr] <= i_wr_blk;
        end
    end

endmodule

// File: rtl/stride_prefetcher.sv
// Multi-stream stride prefetcher. Trained by L1 miss pulses, it keeps a
// fully associative table of ENTRIES streams (one per REGION), learns a block
// stride per stream with a saturating confidence, and once confident issues
// DEGREE prefetch requests. Issued blocks are remembered so L1 lookups can
// report prefetch hits.
//   i_clk, i_reset : clock, async active-low reset
//   pf_bus         : stride_prefetcher_if slave (miss, lookup, pf handshake,
//                    busy and statistics)
//   o_state        : current FSM state
module stride_prefetcher
    import stride_prefetcher_pkg::*;
#(
    parameter int ENTRIES     = DEF_ENTRIES,
    parameter int CONF_THRESH = DEF_CONF_THRESH,
    parameter int DEGREE      = DEF_DEGREE,
    parameter int PF_BUF      = DEF_PF_BUF,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    stride_prefetcher_if.slave   pf_bus,
    output state_t               o_state
);
    localparam int PTR_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int BEAT_W = $clog2(DEGREE + 1);

    state_t                     r_state, w_state_nxt;
    stream_entry_t              r_table [ENTRIES];
    logic [PTR_W-1:0]           r_rr_ptr;
    logic [BLK_W-1:0]           r_miss_blk;
    logic [BLK_W-1:0]           r_pf_blk;
    logic signed [STRIDE_W-1:0] r_stride;
    logic [BEAT_W-1:0]          r_beat;
    logic [CNT_W-1:0]           r_issued_count;
    logic [CNT_W-1:0]           r_useful_count;

    logic [TAG_W-1:0]           w_tag;
    logic                       w_hit;
    logic [PTR_W-1:0]           w_hit_idx;
    logic signed [STRIDE_W-1:0] w_diff;
    logic                       w_same;
    logic [1:0]                 w_new_conf;
    logic                       w_trigger;
    logic                       w_accept;
    logic                       w_last_beat;
    logic                       w_lookup_match;
    logic                       w_addr_off_unused;

    assign w_tag = r_miss_blk[BLK_W-1:REGION_BITS-BLOCK_OFF];

    // Byte offsets within a block carry no information for this design.
    assign w_addr_off_unused = ^{pf_bus.miss_addr[BLOCK_OFF-1:0], pf_bus.lookup_addr[BLOCK_OFF-1:0]};

    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!w_hit && r_table[i].valid && (r_table[i].tag == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_idx = PTR_W'(i);
            end
        end
    end

    // Block delta truncated to the stride width; wraps with block arithmetic.
    assign w_diff     = STRIDE_W'(r_miss_blk - r_table[w_hit_idx].last);
    assign w_same     = (w_diff == r_table[w_hit_idx].stride) && (w_diff != '0);
    assign w_new_conf = !w_same ? 2'd0 :
                        (r_table[w_hit_idx].conf == CONF_MAX) ? CONF_MAX :
                        r_table[w_hit_idx].conf + 2'd1;
    // The updated stride always equals w_diff, so it gates the trigger.
    assign w_trigger  = w_hit && (int'(w_new_conf) >= CONF_THRESH) && (w_diff != '0);

    assign w_accept    = (r_state == ST_ISSUE) && pf_bus.pf_ready;
    assign w_last_beat = (r_beat == BEAT_W'(DEGREE - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (pf_bus.miss_valid) w_state_nxt = ST_UPDATE;
            ST_UPDATE: w_state_nxt = w_trigger ? ST_ISSUE : ST_IDLE;
            ST_ISSUE:  if (w_accept && w_last_beat) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= '0;
            end
            r_rr_ptr   <= '0;
            r_miss_blk <= '0;
            r_pf_blk   <= '0;
            r_stride   <= '0;
            r_beat     <= '0;
        end else begin
            // Only an idle FSM samples misses; others are dropped.
            if (r_state == ST_IDLE && pf_bus.miss_valid) begin
                r_miss_blk <= pf_bus.miss_addr[ADDR_W-1:BLOCK_OFF];
            end
            if (r_state == ST_UPDATE) begin
                if (w_hit) begin
                    r_table[w_hit_idx].last   <= r_miss_blk;
                    r_table[w_hit_idx].stride <= w_diff;
                    r_table[w_hit_idx].conf   <= w_new_conf;
                    if (w_trigger) begin
                        // First request is one stride past the trigger block.
                        r_pf_blk <= r_miss_blk + BLK_W'(w_diff);
                        r_stride <= w_diff;
                        r_beat   <= '0;
                    end
                end else begin
                    r_table[r_rr_ptr] <= '{valid: 1'b1, tag: w_tag, last: r_miss_blk,
                                           stride: '0, conf: 2'd0};
                    r_rr_ptr <= (r_rr_ptr == PTR_W'(ENTRIES - 1)) ? '0 : r_rr_ptr + 1'b1;
                end
            end
            if (w_accept) begin
                r_pf_blk <= r_pf_blk + BLK_W'(r_stride);
                r_beat   <= r_beat + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_issued_count <= '0;
            r_useful_count <= '0;
        end else begin
            if (w_accept && (r_issued_count != '1)) begin
                r_issued_count <= r_issued_count + 1'b1;
            end
            if (w_lookup_match && (r_useful_count != '1)) begin
                r_useful_count <= r_useful_count + 1'b1;
            end
        end
    end

    stride_prefetcher_pf_issue_buffer #(
        .PF_BUF (PF_BUF),
        .BLK_W  (BLK_W)
    ) u_issue_buffer (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_wr_en        (w_accept),
        .i_wr_blk       (r_pf_blk),
        .i_lookup_valid (pf_bus.lookup_valid),
        .i_lookup_blk   (pf_bus.lookup_addr[ADDR_W-1:BLOCK_OFF]),
        .o_match        (w_lookup_match),
        .o_hit          (pf_bus.prefetch_hit)
    );

    assign pf_bus.pf_valid     = (r_state == ST_ISSUE);
    assign pf_bus.pf_addr      = pf_bus.pf_valid ? {r_pf_blk, {BLOCK_OFF{1'b0}}} : '0;
    assign pf_bus.busy         = (r_state != ST_IDLE);
    assign pf_bus.issued_count = r_issued_count;
    assign pf_bus.useful_count = r_useful_count;
    assign o_state             = r_state;

endmodule

// File: tb/tb_stride_prefetcher.sv
// Directed bench for stride_prefetcher. A second instance with 2-bit
// counters shares the stimulus so counter saturation is reachable quickly.
module tb_stride_prefetcher;
    import stride_prefetcher_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stride_prefetcher_if #(.CNT_W(20)) bus ();
    stride_prefetcher_if #(.CNT_W(2))  bus_s ();
    state_t state, state_s;

    stride_prefetcher #(.CNT_W(20)) dut (
        .i_clk(clk), .i_reset(rst_n), .pf_bus(bus), .o_state(state)
    );
    stride_prefetcher #(.CNT_W(2)) dut_s (
        .i_clk(clk), .i_reset(rst_n), .pf_bus(bus_s), .o_state(state_s)
    );

    assign bus_s.miss_valid   = bus.miss_valid;
    assign bus_s.miss_addr    = bus.miss_addr;
    assign bus_s.lookup_valid = bus.lookup_valid;
    assign bus_s.lookup_addr  = bus.lookup_addr;
    assign bus_s.pf_ready     = bus.pf_ready;

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic        saw_valid = 1'b0;

    always @(negedge clk) begin
        if (bus.pf_valid) saw_valid = 1'b1;
        if (bus.pf_valid && bus.pf_ready) got_q.push_back(bus.pf_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pf(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_beat%0d", tag, i),
                  (i < got_q.size()) ? got_q[i] : 32'hDEAD_BEEF, exp_q[i]);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic miss(input logic [31:0] addr);
        bus.miss_valid = 1'b1;
        bus.miss_addr  = addr;
        tick();
        bus.miss_valid = 1'b0;
    endtask

    task automatic miss_idle(input logic [31:0] addr);
        miss(addr);
        idle(4);
    endtask

    task automatic lookup(input logic [31:0] addr);
        bus.lookup_valid = 1'b1;
        bus.lookup_addr  = addr;
        tick();
        bus.lookup_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        tick();
        exp_q.delete();
        got_q.delete();
        saw_valid = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n            = 1'b0;
        bus.miss_valid   = 1'b0;
        bus.miss_addr    = '0;
        bus.lookup_valid = 1'b0;
        bus.lookup_addr  = '0;
        bus.pf_ready     = 1'b0;
        idle(2);
        check("rst_pf_valid", 32'(bus.pf_valid), 0);
        check("rst_busy",     32'(bus.busy), 0);
        check("rst_issued",   bus.issued_count, 0);
        check("rst_useful",   bus.useful_count, 0);
        check("rst_hit",      32'(bus.prefetch_hit), 0);
        check("rst_state",    32'(state), 32'(ST_IDLE));
        rst_n = 1'b1;
        tick();

        // Reset asserted while a request is pending.
        bus.pf_ready = 1'b1;
        for (int i = 0; i < 4; i++) miss_idle(32'h1000 + 32'(i * 16));
        exp_q.push_back(32'h1040);
        exp_q.push_back(32'h1050);
        check_pf("a_train");
        lookup(32'h1044);
        check("a_useful_pre", bus.useful_count, 1);
        bus.pf_ready = 1'b0;
        miss(32'h1040);
        tick();
        check("a_pf_valid_pre", 32'(bus.pf_valid), 1);
        check("a_pf_addr_pre",  bus.pf_addr, 32'h1050);
        #2 rst_n = 1'b0;
        #1;
        check("a_pf_valid_rst", 32'(bus.pf_valid), 0);
        check("a_busy_rst",     32'(bus.busy), 0);
        check("a_issued_rst",   bus.issued_count, 0);
        check("a_useful_rst",   bus.useful_count, 0);
        idle(2);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        got_q.delete();
        bus.pf_ready = 1'b1;
        miss_idle(32'h1050);
        check("a_alloc_only", 32'(saw_valid), 0);
        check("a_issued_post", bus.issued_count, 0);

        // Ascending training, free-flowing handshake, lookups.
        apply_reset();
        bus.pf_ready = 1'b1;
        for (int i = 0; i < 3; i++) miss_idle(32'h1000 + 32'(i * 16));
        check("b_no_pf_early", 32'(saw_valid), 0);
        miss_idle(32'h1030);
        exp_q.push_back(32'h1040);
        exp_q.push_back(32'h1050);
        check_pf("b_asc");
        check("b_issued", bus.issued_count, 2);
        check("b_busy",   32'(bus.busy), 0);
        lookup(32'h1044);
        check("b_hit_1044",    32'(bus.prefetch_hit), 1);
        check("b_useful_1",    bus.useful_count, 1);
        lookup(32'h1040);
        check("b_hit_again",   32'(bus.prefetch_hit), 0);
        check("b_useful_same", bus.useful_count, 1);
        lookup(32'h1058);
        check("b_hit_1058",    32'(bus.prefetch_hit), 1);
        check("b_useful_2",    bus.useful_count, 2);
        lookup(32'h2000);
        check("b_hit_none",    32'(bus.prefetch_hit), 0);

        // Stalled handshake, dropped miss, same-cycle write/lookup.
        apply_reset();
        bus.pf_ready = 1'b0;
        for (int i = 0; i < 3; i++) miss_idle(32'h1000 + 32'(i * 16));
        miss(32'h1030);
        tick();
        check("c_pf_valid", 32'(bus.pf_valid), 1);
        check("c_pf_addr",  bus.pf_addr, 32'h1040);
        check("c_busy",     32'(bus.busy), 1);
        check("c_state",    32'(state), 32'(ST_ISSUE));
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                bus.miss_valid = 1'b1;
                bus.miss_addr  = 32'h5000;
            end
            tick();
            bus.miss_valid = 1'b0;
            check($sformatf("c_stall_valid%0d", i), 32'(bus.pf_valid), 1);
            check($sformatf("c_stall_addr%0d", i),  bus.pf_addr, 32'h1040);
            check($sformatf("c_stall_busy%0d", i),  32'(bus.busy), 1);
        end
        bus.pf_ready     = 1'b1;
        bus.lookup_valid = 1'b1;
        bus.lookup_addr  = 32'h1040;
        tick();
        bus.lookup_valid = 1'b0;
        check("c_same_cycle_hit", 32'(bus.prefetch_hit), 0);
        check("c_beat2_addr",     bus.pf_addr, 32'h1050);
        tick();
        check("c_done_valid", 32'(bus.pf_valid), 0);
        exp_q.push_back(32'h1040);
        exp_q.push_back(32'h1050);
        check_pf("c_stall");
        lookup(32'h1040);
        check("c_hit_later", 32'(bus.prefetch_hit), 1);
        saw_valid = 1'b0;
        for (int i = 1; i < 4; i++) miss_idle(32'h5000 + 32'(i * 16));
        check("c_drop_no_pf", 32'(saw_valid), 0);
        miss_idle(32'h5040);
        exp_q.push_back(32'h5050);
        exp_q.push_back(32'h5060);
        check_pf("c_drop_ctrl");

        // Descending stride -2 blocks.
        apply_reset();
        bus.pf_ready = 1'b1;
        miss_idle(32'h2F00);
        miss_idle(32'h2EE0);
        miss_idle(32'h2EC0);
        miss_idle(32'h2EA0);
        exp_q.push_back(32'h2E80);
        exp_q.push_back(32'h2E60);
        check_pf("d_desc");

        // Round-robin eviction of entry 0 by a fifth region.
        apply_reset();
        miss_idle(32'h1_0000);
        miss_idle(32'h1_0010);
        miss_idle(32'h1_0020);
        miss_idle(32'h2_0000);
        miss_idle(32'h3_0000);
        miss_idle(32'h4_0000);
        miss_idle(32'h5_0000);
        miss_idle(32'h1_0030);
        check_pf("e_evicted");
        miss_idle(32'h3_0010);
        miss_idle(32'h3_0020);
        miss_idle(32'h3_0030);
        exp_q.push_back(32'h3_0040);
        exp_q.push_back(32'h3_0050);
        check_pf("e_survivor");

        // Stride zero never issues.
        apply_reset();
        for (int i = 0; i < 6; i++) miss_idle(32'h3000);
        check("f_zero_no_pf", 32'(saw_valid), 0);
        check_pf("f_zero");

        // Saturation on the 2-bit counter instance.
        apply_reset();
        for (int i = 0; i < 6; i++) miss_idle(32'h1000 + 32'(i * 16));
        exp_q.push_back(32'h1040);
        exp_q.push_back(32'h1050);
        exp_q.push_back(32'h1050);
        exp_q.push_back(32'h1060);
        exp_q.push_back(32'h1060);
        exp_q.push_back(32'h1070);
        check_pf("g_seq");
        check("g_issued",     bus.issued_count, 6);
        check("g_issued_sat", 32'(bus_s.issued_count), 3);
        lookup(32'h1050);
        check("g_hit_1050", 32'(bus.prefetch_hit), 1);
        lookup(32'h1060);
        lookup(32'h1070);
        lookup(32'h1040);
        check("g_hit_1040",     32'(bus.prefetch_hit), 1);
        check("g_useful",       bus.useful_count, 4);
        check("g_useful_sat",   32'(bus_s.useful_count), 3);
        lookup(32'h1050);
        check("g_dup_cleared",  32'(bus.prefetch_hit), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/stride_prefetcher.md
Name: stride_prefetcher

Overview:
Parametrised successor to the single-stream next-line prefetcher. It tracks up to ENTRIES independent access streams and learns a per-stream block stride with a saturating confidence counter. Once confident, it issues DEGREE prefetch requests over a valid/ready handshake. It sits beside the L1 cache: it is trained by L1 miss pulses, answers prefetch-hit lookups from a small buffer of issued blocks, and keeps issued/useful statistics for the simulator readout.

Parameters:
ADDR_W, 32, byte address width
BLOCK_OFF, 4, log2 block size in bytes (16 B)
REGION_BITS, 12, log2 bytes per tracked region; stream tag = addr[ADDR_W-1:REGION_BITS]
ENTRIES, 4, stream table entries (power of 2)
STRIDE_W, 8, signed stride width in blocks
CONF_THRESH, 2, confidence (0..3) required to issue
DEGREE, 2, prefetches issued per trigger (1..8)
PF_BUF, 8, issued-block buffer depth (power of 2)
CNT_W, 20, statistics counter width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low; clears all state
miss_valid  in  1  one-cycle L1 miss pulse
miss_addr  in  ADDR_W  missing byte address, sampled with miss_valid
lookup_valid  in  1  L1 lookup in progress
lookup_addr  in  ADDR_W  byte address being looked up
prefetch_hit  out  1  registered; block found in issued buffer
pf_valid  out  1  prefetch request valid
pf_addr  out  ADDR_W  block-aligned prefetch address, low BLOCK_OFF bits zero
pf_ready  in  1  downstream accepts request
busy  out  1  high whenever FSM is not IDLE
issued_count  out  CNT_W  accepted prefetches, saturating
useful_count  out  CNT_W  prefetch hits, saturating

Behaviour:
- Reset (async, reset==0): FSM=IDLE; all table/buffer valid bits cleared; round-robin pointers=0; all outputs 0.
- blk = addr >> BLOCK_OFF (ADDR_W-BLOCK_OFF bits). Block arithmetic wraps modulo 2^(ADDR_W-BLOCK_OFF).
- FSM IDLE: on miss_valid, capture miss_addr and go to UPDATE. Misses arriving in UPDATE/ISSUE are dropped, not queued.
- UPDATE (1 cycle): fully associative tag match over the table.
  - Table miss: allocate the entry at the round-robin pointer (tag, last=blk, stride=0, conf=0, valid=1); pointer++; go to IDLE.
  - Table hit: d = blk - last, truncated to signed STRIDE_W. If d==stride and d!=0, conf = min(conf+1, 3); otherwise stride=d and conf=0. Set last=blk. If the updated conf >= CONF_THRESH and stride != 0: base=blk, k=1, go to ISSUE; else go to IDLE.
- ISSUE: pf_valid=1, pf_addr=(base + k*stride) << BLOCK_OFF, with stride sign-extended.
  - pf_valid/pf_addr are held stable until pf_ready.
  - Each accepted beat: write blk into the issued buffer at its FIFO pointer (oldest overwritten); issued_count++; k++.
  - After beat DEGREE is accepted, return to IDLE; pf_valid drops the following cycle.
- Lookup: when lookup_valid, compare lookup_addr>>BLOCK_OFF against all valid buffer entries. Cycle t+1: prefetch_hit=1 on a match, the matching entry is invalidated, and useful_count++. Otherwise prefetch_hit=0.
- Simultaneous buffer write and lookup in the same cycle: the lookup sees pre-write contents, so a block written this cycle does not hit.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset asserted mid-ISSUE: abort immediately, pf_valid=0, remaining beats discarded.

Decomposition:
- Shared package: state encoding (IDLE/UPDATE/ISSUE), conf max constant 3, and the stream-entry field layout (valid, tag, last, stride, conf).
- One natural sub-module: pf_issue_buffer. It holds the PF_BUF-entry FIFO-overwrite CAM, write port, lookup/invalidate, and the registered hit output.
- The table, FSM and counters stay in the top module.

Test Plan:
- Reset while in ISSUE with pf_valid=1 -> pf_valid=0 immediately; all counters 0; first miss after release only allocates.
- Misses 0x1000, 0x1010, 0x1020, 0x1030, each separated by ≥3 idle cycles, pf_ready=1 -> no request for the first three; after 0x1030 (conf=2), pf_addr=0x1040 then 0x1050; issued_count=2.
- Same training as above with pf_ready held 0 for 5 cycles -> pf_addr stays 0x1040 and stable; busy=1; a miss to 0x5000 during the stall is dropped (table unchanged).
- Descending misses 0x2F00, 0x2EE0, 0x2EC0, 0x2EA0 (stride -2) -> prefetches 0x2E80 and 0x2E60.
- After issuing 0x1040, lookup 0x1044 -> prefetch_hit=1 next cycle, useful_count=1; repeat lookup 0x1040 -> prefetch_hit=0 (entry invalidated).
- Five distinct regions with ENTRIES=4 -> fifth miss evicts entry 0. Stride-zero repeats of 0x3000 never issue. Preloading issued_count to 2^20-1 and accepting one more beat leaves it at 0xFFFFF.
